// File: rtl/ring_osc_monitor_if.sv
// ring_osc_monitor_if: measurement request and result handshake for ring_osc_monitor.
interface ring_osc_monitor_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic             start;
  logic [WIN_W-1:0] win_len;
  logic             res_ready;
  logic             busy;
  logic             res_valid;
  logic [CNT_W-1:0] res_count;
  logic             res_stuck;
  logic             res_sat;
  modport master (
    output start, win_len, res_ready,
    input  busy, res_valid, res_count, res_stuck, res_sat
  );
  modport slave (
    input  start, win_len, res_ready,
    output busy, res_valid, res_count, res_stuck, res_sat
  );
endinterface

// File: rtl/ring_osc_monitor.sv
// ring_osc_monitor: counts both edges of an asynchronous ring tap over a window of clk cycles.
module ring_osc_monitor #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_in,
  ring_osc_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;
  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [WIN_W-1:0]       r_win;
  logic [CNT_W-1:0]       r_edge, r_res_count;
  logic                   r_sat, r_res_stuck, r_res_sat;
  logic                   w_sync, w_tog, w_last, w_sat_inc;
  logic [CNT_W-1:0]       w_edge_inc;
  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_tog      = w_sync ^ r_prev;
  assign w_last     = r_win == WIN_W'(1);
  assign w_edge_inc = (w_tog && r_edge != '1) ? r_edge + CNT_W'(1) : r_edge;
  assign w_sat_inc  = r_sat | (w_edge_inc == '1);
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = bus.start ? MEASURE : IDLE;
      MEASURE: w_state_nxt = w_last ? DONE : MEASURE;
      DONE:    w_state_nxt = bus.res_ready ? IDLE : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // front end runs in every state so the first window cycle sees no stale edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sync      <= '0;
      r_prev      <= 1'b0;
      r_win       <= '0;
      r_edge      <= '0;
      r_sat       <= 1'b0;
      r_res_count <= '0;
      r_res_stuck <= 1'b0;
      r_res_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], osc_in};
      r_prev  <= w_sync;
      if (r_state == IDLE && bus.start) begin
        r_win  <= (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
        r_edge <= '0;
        r_sat  <= 1'b0;
      end else if (r_state == MEASURE) begin
        r_win  <= r_win - WIN_W'(1);
        r_edge <= w_edge_inc;
        r_sat  <= w_sat_inc;
        if (w_last) begin
          r_res_count <= w_edge_inc;
          r_res_sat   <= w_sat_inc;
          r_res_stuck <= w_edge_inc == '0;
        end
      end
    end
  end
  assign bus.busy      = r_state != IDLE;
  assign bus.res_valid = r_state == DONE;
  assign bus.res_count = r_res_count;
  assign bus.res_stuck = r_res_stuck;
  assign bus.res_sat   = r_res_sat;
endmodule

// File: tb/tb_ring_osc_monitor.sv
// tb_ring_osc_monitor: scoreboard bench for ring_osc_monitor with a 4-bit counter to reach saturation.
module tb_ring_osc_monitor;
  localparam int CW = 4;
  localparam int WW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic osc = 1'b0;
  int per = 0;
  int ph = 0;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    int lat;
    int cnt;
    bit stuck;
    bit sat;
  } exp_t;
  exp_t sb[$];
  ring_osc_monitor_if #(.CNT_W(CW), .WIN_W(WW)) bus ();
  ring_osc_monitor #(.CNT_W(CW), .WIN_W(WW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .osc_in(osc), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // ring model: toggles every per clk cycles, idle when per is 0
  always begin
    @(posedge clk);
    #2;
    if (per != 0) begin
      ph = ph + 1;
      if (ph >= per) begin
        ph = 0;
        osc = ~osc;
      end
    end
  end
  task automatic chk(string tag, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic launch(int wl);
    exp_t e;
    int n, t;
    n = (wl == 0) ? 1 : wl;
    t = (per == 0) ? 0 : n / per;
    e.lat = n + 1;
    e.cnt = (t > 15) ? 15 : t;
    e.stuck = t == 0;
    e.sat = t >= 15;
    sb.push_back(e);
    bus.win_len = WW'(wl);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.win_len = '1;
    chk("busy_after_start", int'(bus.busy), 1);
  endtask
  task automatic wait_result(string tag);
    exp_t e;
    int lat;
    bit got;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    chk({tag, "_valid_seen"}, int'(got), 1);
    e = sb.pop_front();
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_count"}, int'(bus.res_count), e.cnt);
    chk({tag, "_stuck"}, int'(bus.res_stuck), int'(e.stuck));
    chk({tag, "_sat"}, int'(bus.res_sat), int'(e.sat));
  endtask
  task automatic ack(string tag);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk({tag, "_busy_after_ack"}, int'(bus.busy), 0);
    chk({tag, "_valid_after_ack"}, int'(bus.res_valid), 0);
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_valid"}, int'(bus.res_valid), 0);
    chk({tag, "_count"}, int'(bus.res_count), 0);
    chk({tag, "_stuck"}, int'(bus.res_stuck), 0);
    chk({tag, "_sat"}, int'(bus.res_sat), 0);
  endtask
  initial begin
    int held;
    bus.start = 1'b0;
    bus.win_len = '0;
    bus.res_ready = 1'b0;
    per = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      bus.start = i[0];
      bus.win_len = 16'd4;
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk_zero("in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    per = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_no_start", int'(bus.busy | bus.res_valid), 0);
    end
    @(posedge clk);
    #1;
    per = 3;
    repeat (10) @(posedge clk);
    #1;
    launch(30);
    wait_result("nominal");
    ack("nominal");
    per = 0;
    osc = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    launch(8);
    wait_result("stuck8");
    ack("stuck8");
    launch(0);
    wait_result("stuck0");
    ack("stuck0");
    per = 1;
    repeat (6) @(posedge clk);
    #1;
    launch(20);
    wait_result("saturate");
    ack("saturate");
    per = 3;
    repeat (6) @(posedge clk);
    #1;
    launch(30);
    wait_result("bp");
    held = int'(bus.res_count);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.start = (i == 1 || i == 3);
      bus.win_len = 16'd3;
      @(negedge clk);
      chk("bp_valid_held", int'(bus.res_valid), 1);
      chk("bp_count_held", int'(bus.res_count), held);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("bp_still_valid", int'(bus.res_valid), 1);
    ack("bp");
    @(negedge clk);
    chk("bp_starts_ignored", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    launch(6);
    wait_result("bp_fresh");
    ack("bp_fresh");
    bus.win_len = 16'd100;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (39) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    per = 2;
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_idle", int'(bus.busy | bus.res_valid), 0);
    launch(10);
    wait_result("after_reset");
    ack("after_reset");
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
